i2c_slave_mem: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bit_shifter.sv | 37 +++
 rtl/i2c_slave_mem.sv | 151 +++++++++++++++
 tb/tb_i2c_slave_mem.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the i2c_slave_mem target model
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        MEM_ADDR,
        MEM_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        SKIP
    } i2c_state_e;

    localparam logic       ACK            = 1'b0;
    localparam logic       NACK           = 1'b1;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h0B;

    // Bits left in a frame after a non-matching device-address ACK slot.
    localparam int         SKIP_BITS      = 18;

endpackage

// File: rtl/i2c_bit_shifter.sv
// rtl/i2c_bit_shifter.sv - MSB-first shift register with a last-bit flag, shared by rx and tx
module i2c_bit_shifter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         bit_i,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  data_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= {data_q[W-2:0], bit_i};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign data_o = data_q;
    // The count wraps back to zero after the W-th shift, ready for the next byte.
    assign last_o = shift_i && (cnt_q == CW'(W - 1));

endmodule

// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - fixed 28-bit-frame I2C-style target with a 256x8 register memory
module i2c_slave_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         MEM_AW     = 8,
    parameter int         DATA_W     = 8
) (
    input  logic SCL,
    input  logic RESETn,
    input  logic s_sda_i,
    output logic s_sda_o,
    output logic s_sda_o_en
);

    localparam int DEPTH = 2 ** MEM_AW;

    i2c_state_e        state_q, state_d;
    logic              sh_load, sh_shift, sh_last;
    logic [DATA_W-1:0] sh_load_data, sh_data, rx_byte;
    logic              match_q, rw_q;
    logic [MEM_AW-1:0] ptr_q;
    logic [4:0]        skip_cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic              sda_o_q, sda_o_d, sda_en_q, sda_en_d;

    i2c_bit_shifter #(.W(DATA_W)) u_shifter (
        .clk_i       (SCL),
        .rst_ni      (RESETn),
        .load_i      (sh_load),
        .load_data_i (sh_load_data),
        .shift_i     (sh_shift),
        .bit_i       (s_sda_i),
        .data_o      (sh_data),
        .last_o      (sh_last)
    );

    // Byte as it stands once the bit currently on the bus is shifted in.
    assign rx_byte = {sh_data[DATA_W-2:0], s_sda_i};

    always_comb begin
        state_d      = state_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_load_data = '0;
        mem_we       = 1'b0;
        sda_o_d      = NACK;
        sda_en_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_sda_i == 1'b0) begin
                    state_d = DEV_ADDR;
                    sh_load = 1'b1;
                end
            end
            DEV_ADDR: begin
                sh_shift = 1'b1;
                if (sh_last) state_d = DEV_ACK;
            end
            DEV_ACK: begin
                state_d = match_q ? MEM_ADDR : SKIP;
                if (match_q) begin
                    sda_o_d  = ACK;
                    sda_en_d = 1'b1;
                end
            end
            MEM_ADDR: begin
                sh_shift = 1'b1;
                if (sh_last) state_d = MEM_ACK;
            end
            MEM_ACK: begin
                sda_o_d  = ACK;
                sda_en_d = 1'b1;
                if (rw_q) begin
                    state_d      = RD_DATA;
                    sh_load      = 1'b1;
                    sh_load_data = mem_q[ptr_q];
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    state_d = WR_ACK;
                    mem_we  = 1'b1;
                end
            end
            WR_ACK: begin
                sda_o_d  = ACK;
                sda_en_d = 1'b1;
                state_d  = IDLE;
            end
            RD_DATA: begin
                sh_shift = 1'b1;
                sda_o_d  = sh_data[DATA_W-1];
                sda_en_d = 1'b1;
                if (sh_last) state_d = RD_ACK;
            end
            RD_ACK: begin
                state_d = IDLE;
            end
            SKIP: begin
                if (skip_cnt_q == 5'(SKIP_BITS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCL or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            match_q    <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            skip_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DEV_ADDR && sh_last) begin
                match_q <= (rx_byte[7:1] == SLAVE_ADDR);
                rw_q    <= rx_byte[0];
            end
            if (state_q == MEM_ADDR && sh_last) ptr_q <= rx_byte[MEM_AW-1:0];
            skip_cnt_q <= (state_q == SKIP) ? skip_cnt_q + 5'd1 : 5'd0;
        end
    end

    always_ff @(posedge SCL or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    // SDA only moves while SCL is low, so the master always samples a settled level.
    always_ff @(negedge SCL or negedge RESETn) begin
        if (!RESETn) begin
            sda_o_q  <= NACK;
            sda_en_q <= 1'b0;
        end else begin
            sda_o_q  <= sda_o_d;
            sda_en_q <= sda_en_d;
        end
    end

    assign s_sda_o    = sda_o_q;
    assign s_sda_o_en = sda_en_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb/tb_i2c_slave_mem.sv - directed scoreboard bench for i2c_slave_mem
module tb_i2c_slave_mem;

    logic scl   = 1'b0;
    logic rst_n = 1'b0;
    logic m_sda = 1'b1;
    logic sda_bus;
    logic s_sda_o, s_sda_o_en;

    typedef struct {
        int   cyc;
        logic en;
        logic o;
        bit   chk_o;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [256];
    int         tests    = 0;
    int         fails    = 0;
    int         frame_no = 0;

    assign sda_bus = m_sda & (s_sda_o_en ? s_sda_o : 1'b1);

    always #5 scl = ~scl;

    i2c_slave_mem dut (
        .SCL        (scl),
        .RESETn     (rst_n),
        .s_sda_i    (sda_bus),
        .s_sda_o    (s_sda_o),
        .s_sda_o_en (s_sda_o_en)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        exp_t e;
        frame_no++;
        for (int k = 1; k <= n; k++) begin
            e.cyc = k; e.en = 1'b0; e.o = 1'b1; e.chk_o = 1'b0;
            sb.push_back(e);
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge scl); #2;
            e = sb.pop_front();
            check_bit($sformatf("idle%0d c%0d en", frame_no, e.cyc), s_sda_o_en, e.en);
            m_sda = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [6:0] dev, input bit rw, input logic [7:0] addr,
                             input logic [7:0] data, input int abort_at);
        logic [27:0] bits;
        logic [7:0]  rd;
        bit          match;
        exp_t        e;
        frame_no++;
        match = (dev == 7'h0B);
        rd    = model[addr];
        bits  = {1'b0, dev, rw, 1'b1, addr, 1'b1, (rw ? 8'hFF : data), (rw ? 1'b0 : 1'b1)};
        for (int k = 1; k <= 28; k++) begin
            e.cyc = k; e.en = 1'b0; e.o = 1'b1; e.chk_o = 1'b0;
            if (match && (k == 10 || k == 19 || (k == 28 && !rw))) begin
                e.en = 1'b1; e.o = 1'b0; e.chk_o = 1'b1;
            end
            if (match && rw && k >= 20 && k <= 27) begin
                e.en = 1'b1; e.o = rd[27-k]; e.chk_o = 1'b1;
            end
            sb.push_back(e);
        end
        if (match && !rw && abort_at == 0) model[addr] = data;
        for (int k = 1; k <= 28; k++) begin
            @(negedge scl); #2;
            e = sb.pop_front();
            check_bit($sformatf("f%0d c%0d en", frame_no, e.cyc), s_sda_o_en, e.en);
            if (e.chk_o)
                check_bit($sformatf("f%0d c%0d o", frame_no, e.cyc), s_sda_o, e.o);
            m_sda = bits[28-k];
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_bit($sformatf("f%0d abort en", frame_no), s_sda_o_en, 1'b0);
                check_bit($sformatf("f%0d abort o", frame_no), s_sda_o, 1'b1);
                sb.delete();
                foreach (model[i]) model[i] = 8'h00;
                m_sda = 1'b1;
                repeat (2) @(negedge scl);
                #2 rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (model[i]) model[i] = 8'h00;
        rst_n = 1'b0;
        m_sda = 1'b1;
        repeat (3) @(negedge scl);
        #2;
        check_bit("reset o", s_sda_o, 1'b1);
        check_bit("reset en", s_sda_o_en, 1'b0);
        rst_n = 1'b1;

        run_frame(7'h0B, 1'b1, 8'h05, 8'h00, 0);
        run_frame(7'h0B, 1'b0, 8'h05, 8'hA5, 0);
        run_frame(7'h0B, 1'b1, 8'h05, 8'h00, 0);
        run_frame(7'h10, 1'b0, 8'h05, 8'hFF, 0);
        run_frame(7'h0B, 1'b1, 8'h05, 8'h00, 0);
        idle_cycles(5);
        run_frame(7'h0B, 1'b0, 8'hFF, 8'h3C, 0);
        run_frame(7'h0B, 1'b1, 8'hFF, 8'h00, 0);
        run_frame(7'h0B, 1'b0, 8'h00, 8'h5A, 0);
        run_frame(7'h0B, 1'b1, 8'h00, 8'h00, 0);
        run_frame(7'h0B, 1'b1, 8'h05, 8'h00, 0);
        run_frame(7'h0B, 1'b0, 8'h05, 8'hC3, 23);
        run_frame(7'h0B, 1'b1, 8'h05, 8'h00, 0);
        run_frame(7'h0B, 1'b1, 8'hFF, 8'h00, 0);
        run_frame(7'h0B, 1'b0, 8'h05, 8'h96, 0);
        run_frame(7'h0B, 1'b1, 8'h05, 8'h00, 0);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
